// File: rtl/spi_flash_reader.sv
// SPI mode-0 read engine: issues READ + 24-bit address, then streams one
// sector of flash data into a FIFO write port with Full back-pressure.
module spi_flash_reader #(
   parameter int          SECTOR_SHIFT = 9,
   parameter int          CLK_DIV      = 2,
   parameter logic [7:0]  READ_CMD     = 8'h03
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Flash_Read,
   input  logic [23:0] Flash_Start,
   input  logic        Full,
   output logic        WriteFIFO,
   output logic [7:0]  FIFO_data,
   output logic        busy,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   input  logic        miso
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] CS_SETUP = 3'd1;
   localparam logic [2:0] CMD      = 3'd2;
   localparam logic [2:0] ADDR     = 3'd3;
   localparam logic [2:0] DATA     = 3'd4;
   localparam logic [2:0] PUSH     = 3'd5;
   localparam logic [2:0] CS_HOLD  = 3'd6;

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = SECTOR_SHIFT + 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'((1 << SECTOR_SHIFT) - 1);

   logic [2:0]    state;
   logic [DW-1:0] div_cnt;
   logic [4:0]    bit_cnt;
   logic [31:0]   tx;
   logic [7:0]    rx;
   logic [BW-1:0] byte_cnt;
   logic [23:0]   byte_addr;
   logic          div_done;

   assign byte_addr = Flash_Start << SECTOR_SHIFT;
   assign div_done  = (div_cnt == DIV_LAST);

   // sclk doubles as the bit-phase flag: 0 = low phase, 1 = high phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         tx        <= '0;
         rx        <= '0;
         byte_cnt  <= '0;
         cs_n      <= 1'b1;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         busy      <= 1'b0;
         WriteFIFO <= 1'b0;
         FIFO_data <= 8'h00;
      end else begin
         // NOTE: non-blocking default here is overridden by a later <= in the
         // same cycle, so the strobe is a single-cycle pulse without extra logic.
         WriteFIFO <= 1'b0;
         case (state)
            IDLE: begin
               if (Flash_Read) begin
                  state    <= CS_SETUP;
                  cs_n     <= 1'b0;
                  busy     <= 1'b1;
                  tx       <= {READ_CMD, byte_addr};
                  byte_cnt <= '0;
                  div_cnt  <= '0;
               end
            end
            CS_SETUP: begin
               if (div_done) begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= CMD;
                  mosi    <= tx[31];
                  tx      <= {tx[30:0], 1'b0};
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            CMD, ADDR, DATA: begin
               if (!div_done) begin
                  div_cnt <= div_cnt + 1'b1;
               end else if (!sclk) begin
                  div_cnt <= '0;
                  sclk    <= 1'b1;
                  if (state == DATA) rx <= {rx[6:0], miso};
               end else begin
                  div_cnt <= '0;
                  sclk    <= 1'b0;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (state == DATA) begin
                     if (bit_cnt == 5'd7) begin
                        state   <= PUSH;
                        bit_cnt <= '0;
                     end
                  end else if (bit_cnt == 5'd31) begin
                     state   <= DATA;
                     mosi    <= 1'b0;
                     bit_cnt <= '0;
                  end else begin
                     if (bit_cnt == 5'd7) state <= ADDR;
                     mosi <= tx[31];
                     tx   <= {tx[30:0], 1'b0};
                  end
               end
            end
            PUSH: begin
               // Strobe first, advance on the following cycle so the write is
               // always issued from inside PUSH.
               if (WriteFIFO) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  div_cnt  <= '0;
                  state    <= (byte_cnt == BYTE_LAST) ? CS_HOLD : DATA;
               end else if (!Full) begin
                  WriteFIFO <= 1'b1;
                  FIFO_data <= rx;
               end
            end
            CS_HOLD: begin
               if (div_done) begin
                  div_cnt <= '0;
                  cs_n    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader (SECTOR_SHIFT=2, CLK_DIV=1) with a
// behavioural SPI flash that serves A5,3C,FF,01 per sector.
module tb_spi_flash_reader;

   localparam int SS = 2;
   localparam int CD = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        Flash_Read;
   logic [23:0] Flash_Start;
   logic        Full;
   logic        WriteFIFO;
   logic [7:0]  FIFO_data;
   logic        busy;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;

   always #5 clk = ~clk;

   spi_flash_reader #(.SECTOR_SHIFT(SS), .CLK_DIV(CD), .READ_CMD(8'h03)) dut (
      .clk(clk), .rst(rst), .Flash_Read(Flash_Read), .Flash_Start(Flash_Start),
      .Full(Full), .WriteFIFO(WriteFIFO), .FIFO_data(FIFO_data), .busy(busy),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
   );

   logic [7:0]  flash_data [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
   logic [7:0]  exp_q [$];
   logic [31:0] hdr_q [$];
   logic [31:0] hdr;
   int          rcount = 0;
   int          write_cnt = 0;
   int          n_pass = 0;
   int          n_total = 0;
   int          k;
   bit          sclk_q = 1'b0;
   bit          busy_bad = 1'b0;
   bit          mosi_bad = 1'b0;
   bit          stretch_bad = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: event occurred, none expected", name);
   endtask

   // Flash model: drives the next data bit from the count of rising edges seen.
   always_comb begin
      k    = 0;
      miso = 1'b0;
      if (rcount >= 32) begin
         k    = rcount - 32;
         miso = flash_data[(k / 8) % 4][7 - (k % 8)];
      end
   end

   always @(negedge clk) begin
      if (cs_n) begin
         rcount = 0;
         hdr    = '0;
      end else if (sclk && !sclk_q) begin
         rcount++;
         if (rcount <= 32) hdr = {hdr[30:0], mosi};
         else if (mosi) mosi_bad = 1'b1;
         if (rcount == 32) begin
            if (hdr_q.size() == 0) fail_now("header_unexpected");
            else check("header", hdr, hdr_q.pop_front());
         end
      end
      sclk_q = sclk;
      if (!cs_n && !busy) busy_bad = 1'b1;
   end

   // Scoreboard monitor: every FIFO write is matched against the queue.
   always @(negedge clk) begin
      if (WriteFIFO) begin
         write_cnt++;
         if (exp_q.size() == 0) fail_now("unexpected_write");
         else check("fifo_data", {24'h0, FIFO_data}, {24'h0, exp_q.pop_front()});
      end
   end

   task automatic issue(input logic [23:0] start, input bit expect_run);
      logic [23:0] a;
      a = start << SS;
      Flash_Start = start;
      Flash_Read  = 1'b1;
      if (expect_run) begin
         hdr_q.push_back({8'h03, a});
         for (int i = 0; i < 4; i++) exp_q.push_back(flash_data[i]);
      end
      check("cs_n_before_accept", cs_n, 1);
      @(negedge clk);
      Flash_Read = 1'b0;
      check("cs_n_after_accept", cs_n, 0);
      check("busy_after_accept", busy, 1);
   endtask

   task automatic wait_done(input int base);
      int n;
      n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("busy_falls", busy, 0);
      check("sclk_edges", rcount, 64);
      check("cs_n_released", cs_n, 1);
      check("writes_per_request", write_cnt - base, 4);
   endtask

   task automatic wait_rcount(input int target);
      int n;
      n = 0;
      while (rcount != target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("reach_edge_count", rcount, target);
   endtask

   initial begin
      int base;
      int edges_mid;
      rst = 1'b1; Flash_Read = 1'b0; Flash_Start = '0; Full = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 1);
      check("rst_sclk", sclk, 0);
      check("rst_busy", busy, 0);
      check("rst_write", WriteFIFO, 0);
      check("rst_data", FIFO_data, 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset while shifting the address.
      issue(24'h000003, 1'b0);
      wait_rcount(12);
      rst = 1'b1;
      #1;
      check("midrst_cs_n", cs_n, 1);
      check("midrst_sclk", sclk, 0);
      check("midrst_busy", busy, 0);
      check("midrst_write", WriteFIFO, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      base = write_cnt;
      repeat (40) @(negedge clk);
      check("midrst_no_writes", write_cnt - base, 0);
      check("midrst_idle", busy, 0);

      // Header and data bytes.
      base = write_cnt;
      issue(24'h000003, 1'b1);
      wait_done(base);

      // Back-pressure at the second byte.
      base = write_cnt;
      issue(24'h000003, 1'b1);
      wait_rcount(47);
      Full = 1'b1;
      repeat (4) @(negedge clk);
      edges_mid = rcount;
      repeat (16) begin
         @(negedge clk);
         if (sclk || cs_n || WriteFIFO) stretch_bad = 1'b1;
      end
      check("stretch_edges_frozen", rcount, edges_mid);
      check("stretch_edge_count", rcount, 48);
      Full = 1'b0;
      @(negedge clk);
      check("release_write", WriteFIFO, 1);
      check("release_data", FIFO_data, 8'h3C);
      wait_done(base);

      // Request while busy is ignored.
      base = write_cnt;
      issue(24'h000003, 1'b1);
      wait_rcount(20);
      Flash_Start = 24'h000010;
      Flash_Read  = 1'b1;
      @(negedge clk);
      Flash_Read  = 1'b0;
      wait_done(base);
      repeat (20) @(negedge clk);
      check("ignored_no_restart", busy, 0);

      // Back-to-back sectors 0 and 1.
      base = write_cnt;
      issue(24'h000000, 1'b1);
      wait_done(base);
      base = write_cnt;
      issue(24'h000001, 1'b1);
      wait_done(base);

      repeat (5) @(negedge clk);
      check("bytes_left", exp_q.size(), 0);
      check("headers_left", hdr_q.size(), 0);
      check("busy_while_cs", busy_bad, 0);
      check("mosi_low_in_data", mosi_bad, 0);
      check("stretch_held", stretch_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
SPI-master read engine that produces the byte stream the boot loader controller consumes from the RX FIFO.
- On a Flash_Read pulse it issues a standard READ (0x03) command plus a 24-bit address to the SPI flash.
- It then clocks in exactly one sector of data and writes each byte into the FIFO, honouring Full back-pressure.
- It sits between the flash pins and the FIFO write port.

Parameters:
- SECTOR_SHIFT, 9: log2 of sector size in bytes; each request reads 2^SECTOR_SHIFT bytes.
- CLK_DIV, 2: SCLK half-period in clk cycles (>=1); SCLK = clk/(2*CLK_DIV).
- READ_CMD, 8'h03: flash read opcode.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- Flash_Read  input  1  one-cycle request pulse
- Flash_Start  input  24  sector index, sampled with Flash_Read
- Full  input  1  FIFO full
- WriteFIFO  output  1  FIFO write strobe, one cycle per byte
- FIFO_data  output  8  byte to FIFO, valid while WriteFIFO=1
- busy  output  1  request in progress
- sclk  output  1  SPI clock, mode 0
- cs_n  output  1  flash chip select, active low
- mosi  output  1  SPI data out
- miso  input  1  SPI data in

Behaviour:
- Reset (async, any state): cs_n=1, sclk=0, mosi=0, WriteFIFO=0, FIFO_data=8'h00, busy=0, FSM returns to IDLE, all counters cleared. A transfer in flight is abandoned; cs_n rises immediately.
- Byte address = (Flash_Start << SECTOR_SHIFT) truncated to 24 bits, latched when Flash_Read is accepted.
- FSM states: IDLE, CS_SETUP, CMD, ADDR, DATA, PUSH, CS_HOLD.
- IDLE: Flash_Read=1 -> CS_SETUP on the next edge. In the same edge cs_n<=0 and busy<=1. Flash_Read while busy=1 is ignored, with no queueing.
- CS_SETUP: hold for CLK_DIV cycles with sclk=0, then go to CMD.
- Bit timing:
  - Each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - mosi is updated at the start of the low phase, MSB first.
  - miso is sampled on the clk edge where sclk goes 0->1.
- CMD: 8 bits of READ_CMD, then ADDR.
- ADDR: 24 address bits, MSB first, then DATA. mosi=0 during DATA.
- DATA: shift 8 miso bits into the shift register MSB first. After the 8th high phase completes, go to PUSH with sclk=0.
- PUSH:
  - If Full=0: WriteFIFO=1 for exactly one cycle, FIFO_data = assembled byte.
  - If Full=1: wait with sclk held 0 and cs_n held 0 (clock stretch). No write while Full=1.
  - After the write: if bytes written == 2^SECTOR_SHIFT -> CS_HOLD, else -> DATA.
- Byte counter width is SECTOR_SHIFT+1. It is cleared on request accept.
- CS_HOLD: CLK_DIV cycles with sclk=0, then cs_n<=1, busy<=0, and return to IDLE.
- Total SCLK rising edges per request = 32 + 8*2^SECTOR_SHIFT.
- WriteFIFO is never asserted outside PUSH. FIFO_data holds its last value between writes.
- If Full rises in the same cycle the FSM enters PUSH, the write is deferred until Full=0.
- A Flash_Read arriving in the same cycle busy falls is ignored. A request is accepted only when the FSM is in IDLE.

Test Plan:
1. Reset during the ADDR phase -> cs_n=1, sclk=0, busy=0, WriteFIFO=0 on the cycle after rst rises. No FIFO writes follow.
2. Serial header (SECTOR_SHIFT=2, CLK_DIV=1), Flash_Start=24'h000003 -> mosi carries 0x03 then 0x00000C, MSB first, over 32 sclk rising edges. Check cs_n falls one cycle after the pulse and busy=1 throughout.
3. Data bytes (same configuration), flash model returns A5,3C,FF,01 -> exactly 4 WriteFIFO pulses with FIFO_data = A5,3C,FF,01. Check 64 sclk rising edges total and cs_n=1/busy=0 after CS_HOLD.
4. Back-pressure: hold Full=1 for 20 cycles at the 2nd byte -> sclk stays 0 and cs_n stays 0 throughout. The single write of 3C occurs the cycle after Full=0, and all 4 bytes arrive in order.
5. Flash_Read pulse mid-transfer with Flash_Start=24'h000010 -> ignored. The address is unchanged and exactly 4 bytes are written.
6. Two back-to-back requests with sector indices 0 and 1 -> second header address = 0x000004. 8 bytes total reach the FIFO, and cs_n deasserts between the two requests.
